multi_arbiter: RTL
==================

MULTI_ARBITER -- requirements
Module: multi_arbiter

Interface
REQ-001 SHALL have parameter N_PORTS, default 2, number of requesting mem ports (2..8).
REQ-002 SHALL have parameter IDX_W, default $clog2(N_PORTS), width of port index and grant pointer.
REQ-003 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset; state clears immediately on reset=0.
REQ-005 SHALL have port port_in  input  N_PORTS x mem_in_type  per-port requests (mem_valid/instr/addr/wdata/wstrb).
REQ-006 SHALL have port port_out  output  N_PORTS x mem_out_type  per-port responses (mem_ready, mem_rdata).
REQ-007 SHALL have ports memory_valid/memory_instr  output  1/1  memory request strobe and instruction flag.
REQ-008 SHALL have ports memory_addr/memory_wdata/memory_wstrb  output  32/32/4  memory address, write data, byte strobes.
REQ-009 SHALL have ports memory_rdata/memory_ready  input  32/1  memory read data and one-cycle completion pulse.

Function
REQ-010 SHALL hold one pending slot per port; port_in[i].mem_valid=1 loads the slot (a newer request overwrites an unserved one).
REQ-011 SHALL have states IDLE (no transaction) and BUSY (one transaction outstanding, owner index registered).
REQ-012 SHALL consider the arbiter free when in IDLE, or in BUSY with memory_ready=1 that cycle.
REQ-013 SHALL, when free, grant one port among pending slots plus same-cycle valid requests, clear that slot, enter BUSY with new owner.
REQ-014 SHALL, when free with no candidate, go to IDLE.
REQ-015 SHALL drive memory_* combinationally from the granted request in the grant cycle (zero-cycle bypass) and hold them stable from registered copies until memory_ready.
REQ-016 SHALL drive memory_valid and all other memory_* outputs 0 while IDLE and no grant occurs.
REQ-017 SHALL route memory_ready and memory_rdata to port_out[owner] only; all other ports see mem_ready=0, mem_rdata=0.
REQ-018 SHALL route the response to the registered owner even when a new grant issues in the same cycle.
REQ-019 SHALL ignore memory_ready while IDLE.
REQ-020 SHALL never starve a port when round-robin is enabled: maximum wait N_PORTS-1 grants.

Reset
REQ-021 SHALL, on reset=0, force IDLE, clear all slots, owner=0, grant pointer=N_PORTS-1, all memory_* and port_out outputs 0.
REQ-022 SHALL abandon an outstanding transaction on reset mid-operation; no late memory_ready is forwarded afterwards.
REQ-023 SHALL accept requests from the first rising edge after reset deasserts.

Configuration
REQ-024 SHALL, with MULTI_ARBITER_ROUND_ROBIN_EN defined, pick the first candidate searching from pointer+1 modulo N_PORTS, pointer updated to each granted index.
REQ-025 SHALL, without MULTI_ARBITER_ROUND_ROBIN_EN, use fixed priority: highest index wins (data port placed at highest index), pointer unused.

Structure
REQ-026 SHALL place the IDLE/BUSY state enum and the per-port slot struct in the shared wires package; mem_in_type/mem_out_type are reused unchanged.
REQ-027 SHALL implement candidate selection in one combinational sub-module arb_select (inputs candidate mask, pointer; outputs grant index, grant valid).

Verification
REQ-028 SHALL cover: N_PORTS=2, IDLE, port1 valid addr=0x100 -> memory_valid=1, addr=0x100 same cycle; memory_ready+rdata=0xDEADBEEF two cycles later -> port_out[1] ready=1, rdata=0xDEADBEEF, port_out[0] ready=0.
REQ-029 SHALL cover: ports 0 and 1 valid same cycle, fixed priority -> port1 served first, port0 issued in port1's memory_ready cycle.
REQ-030 SHALL cover: N_PORTS=4, round-robin, all ports requesting continuously -> grant order 0,1,2,3,0; no port waits >3 grants.
REQ-031 SHALL cover: port2 re-requests addr 0x20 then 0x24 while BUSY -> only 0x24 issued.
REQ-032 SHALL cover: reset=0 asserted mid-BUSY, memory_ready pulsed after release -> all port_out ready=0, memory_valid=0.
REQ-033 SHALL cover: memory_ready with port0 pending and port1 owner -> port1 gets response, memory_addr switches to port0 request that cycle.

Source files
------------

// File: rtl/multi_arbiter_pkg.sv
// Shared types for the multi-port memory arbiter: the per-port memory request
// and response structs, the arbiter state enum and the pending-slot struct.
package multi_arbiter_pkg;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_type;

  // Request payload without the strobe, as stored in a slot or held for the bus
  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_type;

  typedef struct packed {
    logic    pending;
    req_type req;
  } slot_type;

endpackage

// File: rtl/multi_arbiter_if.sv
// Memory-side bus of the arbiter. The arbiter is the master that issues
// requests; the memory is the slave that returns data with a ready pulse.
interface multi_arbiter_if;

  logic        memory_valid;
  logic        memory_instr;
  logic [31:0] memory_addr;
  logic [31:0] memory_wdata;
  logic [3:0]  memory_wstrb;
  logic [31:0] memory_rdata;
  logic        memory_ready;

  modport master (
    output memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
    input  memory_rdata, memory_ready
  );

  modport slave (
    input  memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
    output memory_rdata, memory_ready
  );

endinterface

// File: rtl/multi_arbiter_arb_select.sv
// Candidate selection for the arbiter (purely combinational).
// With MULTI_ARBITER_ROUND_ROBIN_EN defined the search starts one past the
// pointer and wraps; otherwise the highest-numbered candidate always wins.
module arb_select
  import multi_arbiter_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int IDX_W   = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] cand_mask,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

`ifdef MULTI_ARBITER_ROUND_ROBIN_EN
  logic [2*N_PORTS-1:0] dbl_mask;
  logic [N_PORTS-1:0]   rot_mask;
  int                   offset;

  // Rotate the mask so bit 0 is the port after the pointer, then take the lowest set bit
  always_comb begin
    dbl_mask    = {cand_mask, cand_mask};
    rot_mask    = N_PORTS'(dbl_mask >> (int'(ptr) + 1));
    offset      = 0;
    grant_valid = 1'b0;
    for (int j = N_PORTS - 1; j >= 0; j--) begin
      if (rot_mask[j]) begin
        offset      = j;
        grant_valid = 1'b1;
      end
    end
    grant_idx = IDX_W'((int'(ptr) + 1 + offset) % N_PORTS);
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Fixed priority: the data port sits at the top index, so the highest candidate wins
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (cand_mask[i]) begin
        grant_idx   = IDX_W'(i);
        grant_valid = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/multi_arbiter.sv
// N-port to single memory arbiter. Each port owns one pending slot; when the
// arbiter is free it grants one candidate and drives the memory bus in the
// same cycle, then holds the request from a registered copy until ready.
// Optional feature macro: MULTI_ARBITER_ROUND_ROBIN_EN (round-robin instead
// of fixed highest-index priority).
module multi_arbiter
  import multi_arbiter_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int IDX_W   = $clog2(N_PORTS)
) (
  input  logic            clock,
  input  logic            reset,
  input  mem_in_type      port_in  [N_PORTS],
  output mem_out_type     port_out [N_PORTS],
  multi_arbiter_if.master mem
);

  arb_state_type      state, state_next;
  logic [IDX_W-1:0]   owner, owner_next;
  logic [IDX_W-1:0]   ptr, ptr_next;
  req_type            held, held_next;
  slot_type           slots      [N_PORTS];
  slot_type           slots_next [N_PORTS];

  logic [N_PORTS-1:0] cand_mask;
  req_type            cand_req [N_PORTS];
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_valid;
  logic               free;
  logic               grant;
  req_type            drive_req;

  // A live request on a port shadows whatever its slot still holds
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      cand_mask[i] = slots[i].pending | port_in[i].mem_valid;
      if (port_in[i].mem_valid) begin
        cand_req[i] = '{instr: port_in[i].mem_instr, addr: port_in[i].mem_addr,
                        wdata: port_in[i].mem_wdata, wstrb: port_in[i].mem_wstrb};
      end else begin
        cand_req[i] = slots[i].req;
      end
    end
  end

  arb_select #(
    .N_PORTS (N_PORTS),
    .IDX_W   (IDX_W)
  ) u_select (
    .cand_mask   (cand_mask),
    .ptr         (ptr),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Next-state decision plus the memory bus: bypass on grant, held copy while busy
  always_comb begin
    state_next = state;
    owner_next = owner;
    ptr_next   = ptr;
    held_next  = held;
    drive_req  = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      slots_next[i] = slots[i];
    end
    mem.memory_valid = 1'b0;
    mem.memory_instr = 1'b0;
    mem.memory_addr  = '0;
    mem.memory_wdata = '0;
    mem.memory_wstrb = '0;

    free  = (state == ST_IDLE) || mem.memory_ready;
    grant = reset && free && grant_valid;

    if (grant) begin
      state_next = ST_BUSY;
      owner_next = grant_idx;
      held_next  = cand_req[grant_idx];
`ifdef MULTI_ARBITER_ROUND_ROBIN_EN
      ptr_next   = grant_idx;
`endif
    end else if (free) begin
      state_next = ST_IDLE;
    end

    for (int i = 0; i < N_PORTS; i++) begin
      if (grant && (grant_idx == IDX_W'(i))) begin
        slots_next[i].pending = 1'b0;
      end else if (port_in[i].mem_valid) begin
        slots_next[i] = '{pending: 1'b1, req: cand_req[i]};
      end
    end

    if (grant) begin
      drive_req        = cand_req[grant_idx];
      mem.memory_valid = 1'b1;
    end else if (state == ST_BUSY) begin
      drive_req        = held;
      mem.memory_valid = 1'b1;
    end
    mem.memory_instr = drive_req.instr;
    mem.memory_addr  = drive_req.addr;
    mem.memory_wdata = drive_req.wdata;
    mem.memory_wstrb = drive_req.wstrb;
  end

  // Response goes only to the owner registered for the outstanding transaction
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      port_out[i] = '0;
      if ((state == ST_BUSY) && (owner == IDX_W'(i))) begin
        port_out[i] = '{mem_ready: mem.memory_ready, mem_rdata: mem.memory_rdata};
      end
    end
  end

  // State register; reset drops any outstanding transaction on the spot
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      owner <= '0;
      ptr   <= IDX_W'(N_PORTS - 1);
      held  <= '0;
      for (int i = 0; i < N_PORTS; i++) begin
        slots[i] <= '0;
      end
    end else begin
      state <= state_next;
      owner <= owner_next;
      ptr   <= ptr_next;
      held  <= held_next;
      for (int i = 0; i < N_PORTS; i++) begin
        slots[i] <= slots_next[i];
      end
    end
  end

endmodule
